// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the 800x600@56 scan generator and the renderers
// that consume its coordinates.
package vga_timing_pkg;

  localparam int unsigned COORD_W      = 10;
  localparam int unsigned COORD_LIMIT  = 1 << COORD_W;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 72;
  localparam int unsigned DEF_H_BP     = 128;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 22;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic int unsigned total_len(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned coord_int(input logic [COORD_W-1:0] c);
    return {{(32-COORD_W){1'b0}}, c};
  endfunction

  // Returns the pin level for a sync pulse covering [start, start+width-1].
  function automatic logic sync_window(input logic [COORD_W-1:0] pos, input int unsigned start,
                                       input int unsigned width, input logic pol);
    int unsigned p;
    logic        in_win;
    p      = coord_int(pos);
    in_win = (p >= start) && (p < start + width);
    return in_win ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running scan counters plus a one-stage output register that blanks colour
// and keeps sync aligned with it at the VGA pins.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [3:0]  red_in,
  input  logic [3:0]  green_in,
  input  logic [3:0]  blue_in,
  output logic [9:0]  h_coord,
  output logic [9:0]  v_coord,
  output logic        display_on,
  output logic        active_end,
  output logic [15:0] frame_cnt,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int unsigned H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [9:0]  H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX   = 10'(V_TOTAL - 1);

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_total_chk
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
  end

  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        h_wrap;
  logic        last_px;
  logic        ae_q;
  logic [15:0] fc_q, fc_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  rgb444_t     pix_in;
  rgb444_t     rgb_q, rgb_d;

  assign pix_in = {red_in, green_in, blue_in};

  always_comb begin
    h_wrap = (h_q == H_MAX);
    h_d    = h_wrap ? '0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
    end
  end

  assign display_on = (coord_int(h_q) < H_ACTIVE) && (coord_int(v_q) < V_ACTIVE);

  // Decodes of the current counters; registered below so pins lag the counters by one.
  always_comb begin
    last_px = (coord_int(h_q) == H_ACTIVE - 1) && (coord_int(v_q) == V_ACTIVE - 1);
    fc_d    = fc_q + {15'd0, last_px};
    hs_d    = sync_window(h_q, H_ACTIVE + H_FP, H_SYNC, HS_POL);
    vs_d    = sync_window(v_q, V_ACTIVE + V_FP, V_SYNC, VS_POL);
    rgb_d   = display_on ? pix_in : '0;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= '0;
      v_q   <= '0;
      ae_q  <= 1'b0;
      fc_q  <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      rgb_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      ae_q  <= last_px;
      fc_q  <= fc_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign h_coord    = h_q;
  assign v_coord    = v_q;
  assign active_end = ae_q;
  assign frame_cnt  = fc_q;
  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign vga_r      = rgb_q.r;
  assign vga_g      = rgb_q.g;
  assign vga_b      = rgb_q.b;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing source for the 800x600 @ 56 Hz display path, driven by the 36 MHz pixel clock. It generates the free-running `h_coord`/`v_coord` scan position consumed by game/pattern modules such as the ping-pong renderer. It takes back their combinational 4-bit RGB and drives the physical VGA pins with registered, blanked colour and pipeline-aligned sync pulses. It also provides an active-area-end pulse and a frame counter.

## Interface
Parameters:
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 24: horizontal front porch, in pixels
- `H_SYNC`, 72: hsync width, in pixels
- `H_BP`, 128: horizontal back porch, in pixels
- `V_ACTIVE`, 600: visible lines
- `V_FP`, 1: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 22: vertical back porch, in lines
- `HS_POL`, 1: hsync active level
- `VS_POL`, 1: vsync active level

Ports (clock and reset first):
- `pixel_clk`  in  1  pixel clock, 36 MHz
- `rst_n`  in  1  asynchronous, active-low reset
- `red_in`, `green_in`, `blue_in`  in  4 each  colour from the renderer for the current `h_coord`/`v_coord`
- `h_coord`  out  10  horizontal position, 0..H_TOTAL-1
- `v_coord`  out  10  vertical position, 0..V_TOTAL-1
- `display_on`  out  1  current position is inside the active area
- `active_end`  out  1  one-cycle pulse after the last visible pixel of a frame
- `frame_cnt`  out  16  completed-frame count, wraps
- `vga_hs`, `vga_vs`  out  1 each  sync outputs to the pins
- `vga_r`, `vga_g`, `vga_b`  out  4 each  colour outputs to the pins

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, which is 1024 at defaults
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, which is 625 at defaults
  - Configurations must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024. Check this with an elaboration-time assertion.
- Horizontal counter:
  - `h_coord` increments every clock.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - `v_coord` increments only on the cycle where `h_coord` wraps.
  - At V_TOTAL-1 it wraps to 0; this happens only when both counters are at their maximum.
- `display_on` is a combinational decode of the registered counters: (`h_coord` < H_ACTIVE) && (`v_coord` < V_ACTIVE).
- Sync windows, decoded from the counters:
  - hsync is active for `h_coord` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is [824, 895] at defaults.
  - vsync is active for `v_coord` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is [601, 602] at defaults.
  - An active window drives the output to the `*_POL` level; otherwise the output is at the inverted level.
- Colour stage:
  - `vga_*` <= `display_on` ? `*_in` : 4'h0.
  - Colour is registered every clock, so it is forced to zero everywhere outside the active area.
- `active_end`:
  - Registered; high for exactly one cycle.
  - Fires in the cycle after the counters showed (H_ACTIVE-1, V_ACTIVE-1), i.e. while they read (800, 599).
- `frame_cnt`:
  - Increments in the same cycle that `active_end` is high.
  - Wraps from 0xFFFF to 0.

## Timing
- Reset (asynchronous assert; deassert takes effect on the next `pixel_clk` edge):
  - `h_coord` = 0, `v_coord` = 0, `frame_cnt` = 0
  - `active_end` = 0
  - `vga_r`/`vga_g`/`vga_b` = 0
  - `vga_hs` = ~HS_POL, `vga_vs` = ~VS_POL
  - `display_on` follows from the counters, so it is 1 during reset.
- Pipeline depth is 1 from counters to pins. `vga_hs`, `vga_vs` and `vga_*` at cycle n all reflect the counter value at cycle n-1, so colour and sync stay mutually aligned.
- Renderer path:
  - `*_in` must be a combinational function of `h_coord`/`v_coord`, settling within one pixel clock.
  - No handshake; the generator never stalls.
- Period: one line = H_TOTAL clocks; one frame = H_TOTAL*V_TOTAL clocks (640000 at defaults).
- Reset asserted mid-line: all outputs return to their reset values immediately. The scan restarts at (0,0) on the first edge after release. There is no partial-frame `active_end`.
- `active_end` and `frame_cnt` never fire during reset, including across the (800, 599) point.

## Structure
- Shared package `vga_timing_pkg` holds:
  - default timing localparams for 800x600@56
  - the H_TOTAL/V_TOTAL derivation functions
  - a `rgb444_t` struct typedef, which renderers also use
- No sub-module is required. A single generic `sync_window` comparator function in the package is shared by the h and v decodes.

## Test plan
- Reset values: hold `rst_n`=0 with `red_in`=F → `h_coord`=0, `v_coord`=0, `vga_r`=0, `vga_hs`=0, `vga_vs`=0, `frame_cnt`=0.
- Line wrap: run from reset → `h_coord` goes 1023→0 while `v_coord` goes 0→1 on the same edge; the line period is exactly 1024 clocks.
- Sync windows: `vga_hs`=1 in exactly the cycles following `h_coord` 824..895, which is 72 cycles. `vga_vs`=1 for 2048 cycles following lines 601..602.
- Blanking: `red_in`=F, `green_in`=A, `blue_in`=5 held constant → `vga_*`=F/A/5 one cycle after each (h<800, v<600) position, and 0 elsewhere, including h=800..1023 and v=600..624.
- Frame pulse: run 3 frames → `active_end` pulses exactly 3 times, each while the counters read (800, 599); `frame_cnt`=3. Pulse spacing is 640000 clocks.
- Mid-operation reset: assert `rst_n` at (h=500, v=300) for 3 clocks → outputs return to reset values asynchronously; the scan restarts at (0,0); `frame_cnt` stays 0 until the next full frame completes.
